// File: rtl/frog_controller.sv
`default_nettype none
// ============================================================================
// Module   : frog_controller
// Purpose  : Debounces four buttons, queues one move and animates frog hops,
//            death and respawn, all committed on the frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module frog_controller #(
    parameter int START_X         = 304,
    parameter int START_Y         = 448,
    parameter int MAX_X           = 608,
    parameter int MAX_Y           = 448,
    parameter int HOP_PX          = 32,
    parameter int STEP_PX         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RESPAWN_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [1:0] direction,
    output logic       moving,
    output logic       dead
);

    localparam int c_hop_steps = HOP_PX / STEP_PX;
    localparam int c_db_w      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_step_w    = $clog2(c_hop_steps + 1);
    localparam int c_resp_w    = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [9:0]  c_start_x = 10'(START_X);
    localparam logic [9:0]  c_start_y = 10'(START_Y);
    localparam logic [10:0] c_max_x   = 11'(MAX_X);
    localparam logic [10:0] c_max_y   = 11'(MAX_Y);
    localparam logic [10:0] c_hop     = 11'(HOP_PX);
    localparam logic [9:0]  c_step    = 10'(STEP_PX);

    // Encoding follows the renderer's sprite bank order.
    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_left  = 2'd1;
    localparam logic [1:0] c_dir_right = 2'd2;
    localparam logic [1:0] c_dir_down  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOP  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [3:0]            r_deb_prev;
    logic                  r_pend_valid;
    logic [1:0]            r_pend_dir;
    logic [c_step_w-1:0]   r_step_cnt;
    logic [c_resp_w-1:0]   r_resp_cnt;

    logic [3:0]            w_btn;
    logic [3:0]            w_deb;
    logic [3:0]            w_press;
    logic                  w_press_any;
    logic [1:0]            w_press_dir;
    logic [1:0]            w_mv_dir;
    logic [10:0]           w_x11;
    logic [10:0]           w_y11;
    logic [10:0]           w_tgt;
    logic                  w_in_bounds;
    logic [9:0]            w_next_x;
    logic [9:0]            w_next_y;

    // Bit order: 0 up, 1 down, 2 left, 3 right.
    assign w_btn = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb_prev <= '0;
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_deb_prev <= w_deb;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic [c_db_w-1:0] r_cnt;
        logic              r_level;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[g] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2[g];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_db_w'(1);
            end
        end

        assign w_deb[g] = r_level;
    end

    assign w_press     = w_deb & ~r_deb_prev;
    assign w_press_any = |w_press;

    always_comb begin
        w_press_dir = c_dir_up;
        if (w_press[0]) begin
            w_press_dir = c_dir_up;
        end else if (w_press[1]) begin
            w_press_dir = c_dir_down;
        end else if (w_press[2]) begin
            w_press_dir = c_dir_left;
        end else if (w_press[3]) begin
            w_press_dir = c_dir_right;
        end
    end

    // In IDLE the queued direction drives the bounds check and first step;
    // during a hop the latched facing direction does.
    assign w_mv_dir = (r_state == S_IDLE) ? r_pend_dir : direction;
    assign w_x11    = {1'b0, frog_x};
    assign w_y11    = {1'b0, frog_y};

    always_comb begin
        w_tgt       = '0;
        w_in_bounds = 1'b0;
        w_next_x    = frog_x;
        w_next_y    = frog_y;
        case (w_mv_dir)
            c_dir_up: begin
                w_tgt       = w_y11 - c_hop;
                w_in_bounds = ~w_tgt[10];
                w_next_y    = frog_y - c_step;
            end
            c_dir_left: begin
                w_tgt       = w_x11 - c_hop;
                w_in_bounds = ~w_tgt[10];
                w_next_x    = frog_x - c_step;
            end
            c_dir_right: begin
                w_tgt       = w_x11 + c_hop;
                w_in_bounds = (w_tgt <= c_max_x);
                w_next_x    = frog_x + c_step;
            end
            default: begin
                w_tgt       = w_y11 + c_hop;
                w_in_bounds = (w_tgt <= c_max_y);
                w_next_y    = frog_y + c_step;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            frog_x       <= c_start_x;
            frog_y       <= c_start_y;
            direction    <= c_dir_up;
            moving       <= 1'b0;
            dead         <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= c_dir_up;
            r_step_cnt   <= '0;
            r_resp_cnt   <= '0;
        end else if (collision && (r_state != S_DEAD)) begin
            // Collision beats a coincident frame tick: no step is taken.
            r_state      <= S_DEAD;
            dead         <= 1'b1;
            moving       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_step_cnt   <= '0;
            r_resp_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && r_pend_valid) begin
                        direction    <= r_pend_dir;
                        r_pend_valid <= 1'b0;
                        if (w_in_bounds) begin
                            frog_x     <= w_next_x;
                            frog_y     <= w_next_y;
                            r_step_cnt <= c_step_w'(1);
                            if (c_hop_steps > 1) begin
                                r_state <= S_HOP;
                                moving  <= 1'b1;
                            end
                        end
                    end else if (w_press_any && !r_pend_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_dir   <= w_press_dir;
                    end
                end
                S_HOP: begin
                    if (frame_tick) begin
                        frog_x <= w_next_x;
                        frog_y <= w_next_y;
                        if (r_step_cnt == c_step_w'(c_hop_steps - 1)) begin
                            r_state    <= S_IDLE;
                            moving     <= 1'b0;
                            r_step_cnt <= '0;
                        end else begin
                            r_step_cnt <= r_step_cnt + c_step_w'(1);
                        end
                    end
                end
                S_DEAD: begin
                    if (frame_tick) begin
                        if (r_resp_cnt == c_resp_w'(RESPAWN_FRAMES - 1)) begin
                            r_state    <= S_IDLE;
                            frog_x     <= c_start_x;
                            frog_y     <= c_start_y;
                            direction  <= c_dir_up;
                            dead       <= 1'b0;
                            r_resp_cnt <= '0;
                        end else begin
                            r_resp_cnt <= r_resp_cnt + c_resp_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frog_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_frog_controller
// Purpose  : Directed self-checking bench for frog_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frog_controller;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       frame_tick;
    logic       collision;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [1:0] direction;
    logic       moving;
    logic       dead;

    int checks;
    int failures;

    frog_controller #(
        .START_X        (304),
        .START_Y        (448),
        .MAX_X          (608),
        .MAX_Y          (448),
        .HOP_PX         (32),
        .STEP_PX        (8),
        .DEBOUNCE_CYCLES(4),
        .RESPAWN_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .frame_tick(frame_tick),
        .collision (collision),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .direction (direction),
        .moving    (moving),
        .dead      (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input int x, input int y, input int dir,
                               input int mv, input int dd);
        check_val({tag, "_x"},    32'(frog_x),    32'(x));
        check_val({tag, "_y"},    32'(frog_y),    32'(y));
        check_val({tag, "_dir"},  32'(direction), 32'(dir));
        check_val({tag, "_mov"},  32'(moving),    32'(mv));
        check_val({tag, "_dead"}, 32'(dead),      32'(dd));
    endtask

    // Every step leaves the bench 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right
    task automatic press(input logic [3:0] mask, input int hold);
        btn_up    = mask[0];
        btn_down  = mask[1];
        btn_left  = mask[2];
        btn_right = mask[3];
        cyc(hold);
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cyc(12);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(2);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        frame_tick = 1'b0;
        collision  = 1'b0;

        // 1: reset and idle
        do_reset();
        for (int i = 0; i < 100; i++) begin
            check_val("idle_hold", {8'd0, frog_x, frog_y, direction, moving, dead},
                      {8'd0, 10'd304, 10'd448, 2'd0, 1'b0, 1'b0});
            cyc(1);
        end

        // 2: up hop, four steps of 8 px
        press(4'b0001, 10);
        tick(); check_state("up_t1", 304, 440, 0, 1, 0);
        tick(); check_state("up_t2", 304, 432, 0, 1, 0);
        tick(); check_state("up_t3", 304, 424, 0, 1, 0);
        tick(); check_state("up_t4", 304, 416, 0, 0, 0);
        tick(); check_state("up_t5", 304, 416, 0, 0, 0);

        // down hop back to start
        press(4'b0010, 10);
        tick(); check_state("dn_t1", 304, 424, 3, 1, 0);
        tick(); tick(); tick();
        check_state("dn_t4", 304, 448, 3, 0, 0);

        // left then right hop on the x axis
        press(4'b0100, 10);
        tick(); check_state("lf_t1", 296, 448, 1, 1, 0);
        tick(); tick(); tick();
        check_state("lf_t4", 272, 448, 1, 0, 0);
        press(4'b1000, 10);
        tick(); check_state("rt_t1", 280, 448, 2, 1, 0);
        tick(); tick(); tick();
        check_state("rt_t4", 304, 448, 2, 0, 0);

        // 3: glitch rejected, out-of-bounds down only turns the frog
        do_reset();
        btn_left = 1'b1;
        cyc(2);
        btn_left = 1'b0;
        cyc(12);
        tick(); check_state("glitch", 304, 448, 0, 0, 0);
        press(4'b0010, 10);
        tick(); check_state("oob_dn", 304, 448, 3, 0, 0);
        tick(); check_state("oob_dn2", 304, 448, 3, 0, 0);

        // 4: simultaneous up+right resolves to up; press during hop dropped
        do_reset();
        press(4'b1001, 10);
        tick(); check_state("prio_t1", 304, 440, 0, 1, 0);
        press(4'b1000, 10);
        tick(); tick(); tick();
        check_state("prio_t4", 304, 416, 0, 0, 0);
        tick(); check_state("prio_t5", 304, 416, 0, 0, 0);

        // 5: collision coincident with the second step
        do_reset();
        press(4'b0001, 10);
        tick(); check_state("col_t1", 304, 440, 0, 1, 0);
        frame_tick = 1'b1;
        collision  = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        collision  = 1'b0;
        check_state("col_hit", 304, 440, 0, 0, 1);
        cyc(2);
        tick(); check_state("dead_t1", 304, 440, 0, 0, 1);
        tick(); check_state("dead_t2", 304, 440, 0, 0, 1);
        tick(); check_state("respawn", 304, 448, 0, 0, 0);

        // 6: reset during the second step
        do_reset();
        press(4'b0001, 10);
        tick(); check_state("rst_t1", 304, 440, 0, 1, 0);
        rst_n      = 1'b0;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check_state("rst_hit", 304, 448, 0, 0, 0);
        rst_n = 1'b1;
        cyc(2);
        tick(); check_state("rst_after1", 304, 448, 0, 0, 0);
        tick(); check_state("rst_after2", 304, 448, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
